// File: rtl/ooop_types.sv
// ooop_types: shared types for the out-of-order pipeline.
package ooop_types;
   localparam int PREG_W = 7;
   typedef struct packed {
      logic              valid;
      logic [5:0]        rob_tag;
      logic [3:0]        op;
      logic [PREG_W-1:0] prd;
      logic [PREG_W-1:0] prs1;
      logic              prs1_ready;
      logic              rs1_used;
      logic [PREG_W-1:0] prs2;
      logic              prs2_ready;
      logic              rs2_used;
      logic [31:0]       imm;
   } rs_entry_t;
endpackage

// File: rtl/rs_queue_if.sv
// rs_queue_if: dispatch insert, wakeup broadcast and FU issue signals of a reservation station.
interface rs_queue_if #(parameter int DEPTH = 8, parameter int PREG_W = 7);
   import ooop_types::*;
   logic                       flush;
   logic                       ins_valid;
   logic                       ins_ready;
   rs_entry_t                  ins_entry;
   logic                       wb_valid;
   logic [PREG_W-1:0]          wb_prd;
   logic                       iss_valid;
   logic                       iss_ready;
   rs_entry_t                  iss_entry;
   logic [$clog2(DEPTH+1)-1:0] count;
   modport master (output flush, ins_valid, ins_entry, wb_valid, wb_prd, iss_ready,
                   input  ins_ready, iss_valid, iss_entry, count);
   modport slave  (input  flush, ins_valid, ins_entry, wb_valid, wb_prd, iss_ready,
                   output ins_ready, iss_valid, iss_entry, count);
endinterface

// File: rtl/rs_queue.sv
// rs_queue: reservation station with tag wakeup and oldest-ready-first issue to one FU.
module rs_queue #(
   parameter int DEPTH  = 8,
   parameter int PREG_W = 7
) (
   input logic      clk,
   input logic      rst,
   rs_queue_if.slave q
);
   import ooop_types::*;
   localparam int IW = $clog2(DEPTH);
   localparam int SW = IW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [DEPTH-1:0]  occ;
   logic [DEPTH-1:0]  rdy;
   rs_entry_t         ent [DEPTH];
   logic [SW-1:0]     age [DEPTH];
   logic [SW-1:0]     seq;
   logic [SW-1:0]     d;
   logic [CW-1:0]     count;
   logic [IW-1:0]     sel;
   logic [IW-1:0]     fre;
   logic [PREG_W-1:0] wb_prd;
   logic              any_rdy;
   logic              ins_fire;
   logic              iss_fire;
   rs_entry_t         ins_e;
   assign wb_prd      = q.wb_prd;
   assign q.ins_ready = count != CW'(DEPTH);
   assign q.iss_valid = any_rdy;
   assign q.iss_entry = any_rdy ? ent[sel] : '0;
   assign q.count     = count;
   assign ins_fire    = q.ins_valid && q.ins_ready && !q.flush;
   assign iss_fire    = any_rdy && q.iss_ready && !q.flush;
   // Age difference is wrap-safe: at most DEPTH live ages within a 2*DEPTH ring.
   always_comb begin
      rdy     = '0;
      sel     = '0;
      any_rdy = 1'b0;
      d       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdy[i] = occ[i] && (!ent[i].rs1_used || ent[i].prs1_ready) && (!ent[i].rs2_used || ent[i].prs2_ready);
         d = age[i] - age[sel];
         if (rdy[i] && (!any_rdy || d[SW-1])) begin
            sel     = IW'(i);
            any_rdy = 1'b1;
         end
      end
   end
   always_comb begin
      fre = '0;
      for (int i = DEPTH - 1; i >= 0; i--) fre = occ[i] ? fre : IW'(i);
   end
   always_comb begin
      ins_e            = q.ins_entry;
      ins_e.valid      = 1'b1;
      ins_e.prs1_ready = q.ins_entry.prs1_ready || (q.wb_valid && q.ins_entry.prs1 == wb_prd);
      ins_e.prs2_ready = q.ins_entry.prs2_ready || (q.wb_valid && q.ins_entry.prs2 == wb_prd);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ   <= '0;
         seq   <= '0;
         count <= '0;
         ent   <= '{default: '0};
         age   <= '{default: '0};
      end else if (q.flush) begin
         occ   <= '0;
         seq   <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q.wb_valid && occ[i] && ent[i].rs1_used && ent[i].prs1 == wb_prd) ent[i].prs1_ready <= 1'b1;
            if (q.wb_valid && occ[i] && ent[i].rs2_used && ent[i].prs2 == wb_prd) ent[i].prs2_ready <= 1'b1;
         end
         if (iss_fire) occ[sel] <= 1'b0;
         if (ins_fire) begin
            occ[fre] <= 1'b1;
            ent[fre] <= ins_e;
            age[fre] <= seq;
            seq      <= seq + 1'b1;
         end
         count <= count + CW'(ins_fire) - CW'(iss_fire);
      end
   end
endmodule

// File: doc/rs_queue.md
# rs_queue

Reservation station that accepts the per-FU insert stream produced by dispatch and sends entries to one functional unit. It holds up to DEPTH `ooop_types::rs_entry_t` entries and tracks operand readiness through a result-tag wakeup broadcast. It presents one ready entry per cycle to the FU using a valid/ready handshake. One instance sits between dispatch and each of the ALU, BRU and LSU pipes.

## Interface
- DEPTH, 8, number of entry slots (power of two, ≥2)
- PREG_W, 7, physical-register tag width; must equal width of rs_entry_t prs1/prs2/prd
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush_i  input  1  synchronous clear of all entries
- ins_valid_i  input  1  dispatch insert request (rs_*_valid_o from dispatch)
- ins_ready_o  output  1  space available (drives dispatch rs_*_ready_i)
- ins_entry_i  input  rs_entry_t  entry to insert
- wb_valid_i  input  1  wakeup broadcast valid
- wb_prd_i  input  PREG_W  physical tag that became ready
- iss_valid_o  output  1  an issuable entry is presented
- iss_ready_i  input  1  FU accepts the presented entry
- iss_entry_o  output  rs_entry_t  presented entry, '0 when iss_valid_o=0
- count_o  output  $clog2(DEPTH+1)  number of occupied slots

## Operation
- Storage: DEPTH slots, each with an occupied bit plus one rs_entry_t. Each slot also keeps a per-slot age value so the oldest entry can be found.
- ins_ready_o = (count_o != DEPTH). It is computed from registered state only; a same-cycle issue does not open space.
- Insert fires when ins_valid_i && ins_ready_o && !flush_i:
  - entry goes into the lowest-index free slot;
  - stored valid bit is forced to 1;
  - age is set to the insert sequence number.
- Operand readiness of a slot: op1_ok = !rs1_used || prs1_ready; op2_ok = !rs2_used || prs2_ready. The slot is issuable when occupied && op1_ok && op2_ok.
- Wakeup, when wb_valid_i:
  - every occupied slot with rs1_used && prs1==wb_prd_i sets prs1_ready; same rule for prs2.
  - Insert bypass: an entry inserted in the same cycle whose prs1/prs2 match wb_prd_i is stored with the matching ready bit already set.
- Select: among issuable slots, present the one with the oldest age. Age is compared with wrap-safe subtraction on a $clog2(DEPTH)+1-bit sequence counter.
  - iss_valid_o=1 if any slot is issuable.
  - iss_entry_o is that slot's stored entry, with ready bits as currently registered.
- Issue fires when iss_valid_o && iss_ready_i && !flush_i. The selected slot is freed at the edge.
- Insert and issue in the same cycle are both allowed. count_o changes by +1, -1, or 0.
- Flush: clears all occupied bits and resets the sequence counter to 0. Flush takes priority over insert, wakeup, and issue in the same cycle.
- Reset values: all slots unoccupied, sequence counter 0, count_o=0, ins_ready_o=1, iss_valid_o=0, iss_entry_o='0.
- Entries with both operands unused (rs1_used=rs2_used=0) are issuable the cycle after insert.

## Timing
- Insert→issue latency is 1 cycle minimum. An inserted entry is visible on iss_valid_o in the cycle after the insert edge, never combinationally in the same cycle.
- Wakeup→issue latency is 1 cycle. A slot woken at edge N can be presented in cycle N+1. There is no combinational wb→iss path.
- iss_valid_o and iss_entry_o depend only on registered state. They may change selection when iss_ready_i=0 if an older entry becomes issuable; the FU must not assume the selection is held.
- Full: count_o=DEPTH drives ins_ready_o=0 even if an issue fires this cycle. The next cycle shows ready=1.
- Empty: iss_valid_o=0 and iss_entry_o='0.
- Sequence counter wraps modulo 2·DEPTH. The age compare stays correct because at most DEPTH entries are live.
- rst asserted mid-operation clears state immediately, without waiting for clk. Outputs take reset values while rst=1.

## Test plan
- **Reset/empty:** assert rst with no clock edges → iss_valid_o=0, ins_ready_o=1, count_o=0. Then insert an entry with both operands ready and rob_tag=5 → next cycle iss_valid_o=1, iss_entry_o.rob_tag=5.
- **Wakeup:** insert entry A with prs1=12, prs1_ready=0, rs1_used=1 → iss_valid_o stays 0. Pulse wb_valid_i with wb_prd_i=12 → one cycle later iss_valid_o=1 and iss_entry_o.prs1_ready=1.
- **Insert bypass:** insert an entry with prs2=20 not ready while wb_prd_i=20 is valid in the same cycle → issuable next cycle; no second wakeup needed.
- **Age order:** insert 3 ready entries with rob_tag 1, 2, 3 while iss_ready_i=0, then raise iss_ready_i → issued in order 1, 2, 3 on consecutive cycles; count_o goes 3→0.
- **Full:** fill 8 unready entries → ins_ready_o=0 and a held ins_valid_i is not taken. Wake one and issue it → ins_ready_o=1 the following cycle, and the pending entry lands in the freed slot.
- **Flush:** with 5 entries occupied, assert flush_i together with ins_valid_i and iss_ready_i → next cycle count_o=0, iss_valid_o=0, nothing inserted, nothing issued.
